fht_stream_io: RTL and testbench

Streaming load/unload front-end for the FHT core. It accepts a valid/ready stream of ADC samples and distributes them round-robin into the BANKS RAM banks of bank A, sign-extending each by one bit. It then pulses the core start, waits for the transform to finish, and streams the results back out in sample order with full backpressure. It replaces the manual per-bank external address, write-enable and read ports of the current top level, and it drives the SOURCE_CONT bank-ownership select itself.

---
 rtl/fht_stream_io.sv | 178 +++++++++++++++++
 tb/tb_fht_stream_io.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fht_stream_io.sv
// Streaming load/unload front-end for the FHT core: round-robin bank loader,
// core start/finish handshake, and an in-order backpressured result reader.
module fht_stream_io #(
    parameter int D_BIT = 17,
    parameter int A_BIT = 8,
    parameter int BANKS = 4
) (
    input  logic                     iCLK,
    input  logic                     iRESET,
    input  logic                     iIN_VALID,
    input  logic signed [D_BIT-2:0]  iIN_DATA,
    output logic                     oIN_READY,
    output logic                     oSOURCE_CONT,
    output logic [BANKS-1:0]         oWE,
    output logic [A_BIT-1:0]         oADDR_WR,
    output logic signed [D_BIT-1:0]  oDATA_WR,
    output logic [A_BIT-1:0]         oADDR_RD,
    input  logic [BANKS*D_BIT-1:0]   iRAM_RE,
    output logic                     oSTART,
    input  logic                     iCORE_RDY,
    output logic                     oOUT_VALID,
    output logic signed [D_BIT-1:0]  oOUT_DATA,
    output logic                     oOUT_LAST,
    input  logic                     iOUT_READY,
    output logic                     oERR
);
    localparam int LOG2B = $clog2(BANKS);
    localparam int CW    = A_BIT + LOG2B;
    // N is a power of two, so the last sample index is all ones
    localparam logic [CW-1:0]    LAST_IDX = {CW{1'b1}};
    localparam logic [BANKS-1:0] WE_ONE   = {{(BANKS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_LOAD, S_FLUSH, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_UNLOAD
    } state_t;

    function automatic logic signed [D_BIT-1:0] sign_ext(input logic signed [D_BIT-2:0] x);
        return {x[D_BIT-2], x};
    endfunction

    state_t                   state;
    logic [CW-1:0]            wr_cnt;
    logic [CW-1:0]            rd_cnt;
    logic                     rd_all;
    logic [1:0]               busy_cnt;

    logic                     vld_p1;
    logic                     last_p1;
    logic [LOG2B-1:0]         bank_sel_p1;
    logic signed [D_BIT-1:0]  ram_word_p1;

    logic signed [D_BIT-1:0]  fifo_data [2];
    logic                     fifo_last [2];
    logic                     wptr;
    logic                     rptr;
    logic [1:0]               occ;

    logic                     in_acc;
    logic                     out_pop;
    logic                     last_pop;
    logic                     issue;

    assign oIN_READY    = (state == S_LOAD);
    assign oSOURCE_CONT = !(state inside {S_START, S_WAIT_BUSY, S_WAIT_DONE});
    assign in_acc       = iIN_VALID && oIN_READY;

    assign oOUT_VALID   = (occ != 2'd0);
    assign oOUT_DATA    = fifo_data[rptr];
    assign oOUT_LAST    = oOUT_VALID && fifo_last[rptr];
    assign out_pop      = oOUT_VALID && iOUT_READY;
    assign last_pop     = out_pop && oOUT_LAST;

    // A pop in the same cycle frees a slot, which keeps full-rate unload at 1 word/cycle
    assign issue = (state == S_UNLOAD) && !rd_all &&
                   ((3'(occ) + 3'(vld_p1)) < (3'd2 + 3'(out_pop)));

    assign oADDR_RD    = rd_cnt[CW-1:LOG2B];
    assign ram_word_p1 = iRAM_RE[bank_sel_p1*D_BIT +: D_BIT];

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state    <= S_LOAD;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            rd_all   <= 1'b0;
            busy_cnt <= '0;
            oSTART   <= 1'b0;
            oERR     <= 1'b0;
            oWE      <= '0;
            oADDR_WR <= '0;
            oDATA_WR <= '0;
        end else begin
            oSTART <= 1'b0;
            oWE    <= '0;
            case (state)
                S_LOAD: begin
                    if (in_acc) begin
                        oWE      <= WE_ONE << wr_cnt[LOG2B-1:0];
                        oADDR_WR <= wr_cnt[CW-1:LOG2B];
                        oDATA_WR <= sign_ext(iIN_DATA);
                        if (wr_cnt == LAST_IDX) state <= S_FLUSH;
                        else                    wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    state  <= S_START;
                    oSTART <= 1'b1;
                end
                S_START: begin
                    state    <= S_WAIT_BUSY;
                    busy_cnt <= '0;
                end
                S_WAIT_BUSY: begin
                    if (!iCORE_RDY) begin
                        state <= S_WAIT_DONE;
                    end else if (busy_cnt == 2'd3) begin
                        oERR  <= 1'b1;
                        state <= S_WAIT_DONE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (iCORE_RDY) state <= S_UNLOAD;
                end
                S_UNLOAD: begin
                    if (issue) begin
                        if (rd_cnt == LAST_IDX) rd_all <= 1'b1;
                        else                    rd_cnt <= rd_cnt + 1'b1;
                    end
                    if (last_pop) begin
                        state  <= S_LOAD;
                        wr_cnt <= '0;
                        rd_cnt <= '0;
                        rd_all <= 1'b0;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // p0 -> p1: address issued, bank select and last flag wait for the RAM read
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            bank_sel_p1 <= '0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                bank_sel_p1 <= rd_cnt[LOG2B-1:0];
                last_p1     <= (rd_cnt == LAST_IDX);
            end
        end
    end

    // p1 -> skid: RAM word muxed by bank and queued for the consumer
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            wptr <= 1'b0;
            rptr <= 1'b0;
            occ  <= '0;
        end else begin
            if (vld_p1) begin
                fifo_data[wptr] <= ram_word_p1;
                fifo_last[wptr] <= last_p1;
                wptr            <= ~wptr;
            end
            if (out_pop) rptr <= ~rptr;
            occ <= occ + 2'(vld_p1) - 2'(out_pop);
        end
    end
endmodule

// File: tb/tb_fht_stream_io.sv
// Self-checking bench for fht_stream_io with a bank RAM model and event logs.
module tb_fht_stream_io;
    localparam int D_BIT = 17;
    localparam int A_BIT = 3;
    localparam int BANKS = 4;
    localparam int DEPTH = 8;
    localparam int N     = 32;

    logic                    iCLK = 1'b0;
    logic                    iRESET = 1'b0;
    logic                    iIN_VALID = 1'b0;
    logic [D_BIT-2:0]        iIN_DATA = '0;
    logic                    oIN_READY, oSOURCE_CONT, oSTART, oOUT_VALID, oOUT_LAST, oERR;
    logic [BANKS-1:0]        oWE;
    logic [A_BIT-1:0]        oADDR_WR, oADDR_RD;
    logic [D_BIT-1:0]        oDATA_WR, oOUT_DATA;
    logic [BANKS*D_BIT-1:0]  iRAM_RE;
    logic                    iCORE_RDY = 1'b1;
    logic                    iOUT_READY = 1'b1;

    fht_stream_io #(.D_BIT(D_BIT), .A_BIT(A_BIT), .BANKS(BANKS)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iIN_VALID(iIN_VALID), .iIN_DATA(iIN_DATA),
        .oIN_READY(oIN_READY), .oSOURCE_CONT(oSOURCE_CONT), .oWE(oWE),
        .oADDR_WR(oADDR_WR), .oDATA_WR(oDATA_WR), .oADDR_RD(oADDR_RD),
        .iRAM_RE(iRAM_RE), .oSTART(oSTART), .iCORE_RDY(iCORE_RDY),
        .oOUT_VALID(oOUT_VALID), .oOUT_DATA(oOUT_DATA), .oOUT_LAST(oOUT_LAST),
        .iOUT_READY(iOUT_READY), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Bank RAM: write when this block owns the ports, 1-cycle registered read
    logic [D_BIT-1:0] ram [BANKS][DEPTH];
    always @(posedge iCLK) begin
        for (int b = 0; b < BANKS; b++) begin
            if (oSOURCE_CONT && oWE[b]) ram[b][oADDR_WR] <= oDATA_WR;
            iRAM_RE[b*D_BIT +: D_BIT] <= ram[b][oADDR_RD];
        end
    end

    // Event logs, sampled mid-cycle
    int               acc_cyc[$];
    int               w_cyc[$];
    logic [BANKS-1:0] w_we[$];
    logic [A_BIT-1:0] w_addr[$];
    logic [D_BIT-1:0] w_data[$];
    logic             w_src[$];
    int               start_cyc[$];
    int               src_rise[$], src_fall[$], rdy_rise[$], rdy_fall[$];
    logic [D_BIT-1:0] o_data[$];
    logic             o_last[$];
    int               o_cyc[$];
    int               stall_viol = 0;
    logic             prev_src = 1'b1, prev_rdy = 1'b1, prev_stall = 1'b0, prev_last = 1'b0;
    logic [D_BIT-1:0] prev_data = '0;

    always @(negedge iCLK) begin
        if (iRESET) begin
            if (iIN_VALID && oIN_READY) acc_cyc.push_back(cyc);
            if (oWE != '0) begin
                w_cyc.push_back(cyc); w_we.push_back(oWE); w_addr.push_back(oADDR_WR);
                w_data.push_back(oDATA_WR); w_src.push_back(oSOURCE_CONT);
            end
            if (oSTART) start_cyc.push_back(cyc);
            if (oSOURCE_CONT && !prev_src) src_rise.push_back(cyc);
            if (!oSOURCE_CONT && prev_src) src_fall.push_back(cyc);
            if (oIN_READY && !prev_rdy) rdy_rise.push_back(cyc);
            if (!oIN_READY && prev_rdy) rdy_fall.push_back(cyc);
            if (oOUT_VALID && iOUT_READY) begin
                o_data.push_back(oOUT_DATA); o_last.push_back(oOUT_LAST); o_cyc.push_back(cyc);
            end
            if (prev_stall && (!oOUT_VALID || oOUT_DATA !== prev_data || oOUT_LAST !== prev_last))
                stall_viol <= stall_viol + 1;
            prev_src   <= oSOURCE_CONT;
            prev_rdy   <= oIN_READY;
            prev_stall <= oOUT_VALID && !iOUT_READY;
            prev_data  <= oOUT_DATA;
            prev_last  <= oOUT_LAST;
        end else begin
            prev_src   <= 1'b1;
            prev_rdy   <= 1'b1;
            prev_stall <= 1'b0;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [D_BIT-2:0] samp [N];

    // Reference: the sample read as a signed number, re-encoded in D_BIT bits
    function automatic logic [D_BIT-1:0] ext_ref(input logic [D_BIT-2:0] x);
        int v;
        v = (int'(x) >= 2**(D_BIT-2)) ? int'(x) - 2**(D_BIT-1) : int'(x);
        return D_BIT'(v);
    endfunction

    task automatic do_reset();
        iRESET = 1'b0; iIN_VALID = 1'b0; iCORE_RDY = 1'b1; iOUT_READY = 1'b1;
        repeat (3) @(posedge iCLK);
        #1 iRESET = 1'b1;
        @(posedge iCLK); #1;
    endtask

    task automatic drive_load(input int pct, input bit corner, input bit junk_after);
        for (int n = 0; n < N; n++) begin
            int done = 0;
            int guard = 0;
            if (corner && n == 0)      samp[n] = 16'h8000;
            else if (corner && n == 1) samp[n] = 16'h7FFF;
            else                       samp[n] = 16'($urandom);
            while (done == 0) begin
                iIN_VALID = ($urandom_range(99) < pct);
                iIN_DATA  = samp[n];
                done = (iIN_VALID && oIN_READY) ? 1 : 0;
                @(posedge iCLK); #1;
                guard++;
                if (guard > 200) begin
                    n_cmp++; n_err++;
                    $display("FAIL load_accept sample %0d not accepted within 200 cycles", n);
                    iIN_VALID = 1'b0;
                    return;
                end
            end
        end
        iIN_VALID = junk_after;
        iIN_DATA  = 16'($urandom);
    endtask

    task automatic wait_start(output int s);
        int guard = 0;
        while (!oSTART && guard < 20) begin
            @(posedge iCLK); #1;
            guard++;
        end
        s = cyc;
        if (!oSTART) begin
            n_cmp++; n_err++;
            $display("FAIL start_wait oSTART got 0 want 1 within 20 cycles");
        end
    endtask

    task automatic drive_core(input int busy, output int s, output int r);
        wait_start(s);
        @(posedge iCLK); #1;
        iCORE_RDY = 1'b0;
        repeat (busy) begin
            @(posedge iCLK); #1;
        end
        iCORE_RDY = 1'b1;
        r = cyc;
    endtask

    task automatic drive_unload(input int pct);
        int guard = 0;
        int fin = 0;
        while (fin == 0) begin
            iOUT_READY = ($urandom_range(99) < pct);
            fin = (oOUT_VALID && iOUT_READY && oOUT_LAST) ? 1 : 0;
            if (fin != 0) iIN_VALID = 1'b0;
            @(posedge iCLK); #1;
            guard++;
            if (guard > 600) begin
                n_cmp++; n_err++;
                $display("FAIL unload_done last word not accepted within 600 cycles");
                fin = 1;
            end
        end
        iIN_VALID = 1'b0;
        iOUT_READY = 1'b1;
        @(posedge iCLK); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [15:0] got;
        got = {oIN_READY, oSOURCE_CONT, oWE, oSTART, oOUT_VALID, oOUT_LAST, oERR, 6'd0};
        n_cmp++;
        if (got !== 16'b1100_0000_0000_0000) begin
            n_err++;
            $display("FAIL %s_ctrl got %b want 1100000000000000", tag, got);
        end
        n_cmp++;
        if ({oADDR_WR, oADDR_RD} !== '0) begin
            n_err++;
            $display("FAIL %s_addr got wr=%0d rd=%0d want 0 0", tag, oADDR_WR, oADDR_RD);
        end
        n_cmp++;
        if ({oDATA_WR, oOUT_DATA} !== '0) begin
            n_err++;
            $display("FAIL %s_data got wr=%h out=%h want 0 0", tag, oDATA_WR, oOUT_DATA);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset");
    endtask

    task automatic check_outputs(input string tag, input int bo, input int bs);
        int cnt;
        cnt = o_data.size() - bo;
        n_cmp++;
        if (cnt != N) begin
            n_err++;
            $display("FAIL %s_count got %0d words want %0d", tag, cnt, N);
        end
        for (int k = 0; k < N && k < cnt; k++) begin
            n_cmp++;
            if (o_data[bo+k] !== ext_ref(samp[k]) || o_last[bo+k] !== (k == N-1)) begin
                n_err++;
                $display("FAIL %s_word[%0d] got data=%h last=%b want data=%h last=%b",
                         tag, k, o_data[bo+k], o_last[bo+k], ext_ref(samp[k]), k == N-1);
            end
        end
        n_cmp++;
        if (stall_viol != bs) begin
            n_err++;
            $display("FAIL %s_stall_stable got %0d violations want 0", tag, stall_viol - bs);
        end
    endtask

    task automatic test_load_mapping();
        int ba, bw, cnt, s, r;
        logic [BANKS-1:0] ew;
        ba = acc_cyc.size(); bw = w_cyc.size();
        drive_load(100, 1'b1, 1'b0);
        drive_core(10, s, r);
        drive_unload(100);
        cnt = w_cyc.size() - bw;
        n_cmp++;
        if (cnt != N) begin
            n_err++;
            $display("FAIL load_write_count got %0d want %0d", cnt, N);
        end
        for (int n = 0; n < N && n < cnt && ba + n < acc_cyc.size(); n++) begin
            ew = '0; ew[n % BANKS] = 1'b1;
            n_cmp++;
            if (w_cyc[bw+n] != acc_cyc[ba+n] + 1 || w_we[bw+n] !== ew || w_src[bw+n] !== 1'b1 ||
                w_addr[bw+n] !== A_BIT'(n / BANKS) || w_data[bw+n] !== ext_ref(samp[n])) begin
                n_err++;
                $display("FAIL load_write[%0d] got cyc=%0d we=%b addr=%0d data=%h src=%b want cyc=%0d we=%b addr=%0d data=%h src=1",
                         n, w_cyc[bw+n], w_we[bw+n], w_addr[bw+n], w_data[bw+n], w_src[bw+n],
                         acc_cyc[ba+n] + 1, ew, n / BANKS, ext_ref(samp[n]));
            end
        end
        if (cnt >= 2) begin
            n_cmp++;
            if (w_data[bw] !== 17'h18000 || w_data[bw+1] !== 17'h07FFF) begin
                n_err++;
                $display("FAIL load_sign_ext got %h %h want 18000 07fff", w_data[bw], w_data[bw+1]);
            end
        end
    endtask

    task automatic test_gapped_input();
        int ba, bw, bs, brf, brr, s, r, last_acc;
        ba = acc_cyc.size(); bw = w_cyc.size(); bs = start_cyc.size();
        brf = rdy_fall.size(); brr = rdy_rise.size();
        drive_load(50, 1'b0, 1'b1);
        drive_core(10, s, r);
        drive_unload(100);
        n_cmp++;
        if (acc_cyc.size() - ba != N || w_cyc.size() - bw != N) begin
            n_err++;
            $display("FAIL gap_counts got acc=%0d writes=%0d want %0d %0d",
                     acc_cyc.size() - ba, w_cyc.size() - bw, N, N);
        end
        last_acc = (acc_cyc.size() > ba) ? acc_cyc[acc_cyc.size()-1] : -100;
        n_cmp++;
        if (start_cyc.size() - bs != 1 || s != last_acc + 2) begin
            n_err++;
            $display("FAIL gap_start got pulses=%0d at=%0d want 1 at %0d",
                     start_cyc.size() - bs, s, last_acc + 2);
        end
        n_cmp++;
        if (rdy_fall.size() - brf != 1 || rdy_rise.size() - brr != 1 ||
            rdy_fall[rdy_fall.size()-1] != last_acc + 1) begin
            n_err++;
            $display("FAIL gap_ready got falls=%0d rises=%0d fall_at=%0d want 1 1 %0d",
                     rdy_fall.size() - brf, rdy_rise.size() - brr,
                     rdy_fall[rdy_fall.size()-1], last_acc + 1);
        end
    endtask

    task automatic test_core_handshake();
        int bf, br, s, r;
        bf = src_fall.size(); br = src_rise.size();
        drive_load(100, 1'b0, 1'b0);
        drive_core(50, s, r);
        drive_unload(100);
        n_cmp++;
        if (src_fall.size() - bf != 1 || src_fall[src_fall.size()-1] != s) begin
            n_err++;
            $display("FAIL core_src_fall got n=%0d at=%0d want 1 at %0d",
                     src_fall.size() - bf, src_fall[src_fall.size()-1], s);
        end
        n_cmp++;
        if (src_rise.size() - br != 1 || src_rise[src_rise.size()-1] != r + 1) begin
            n_err++;
            $display("FAIL core_unload_entry got n=%0d at=%0d want 1 at %0d",
                     src_rise.size() - br, src_rise[src_rise.size()-1], r + 1);
        end
        n_cmp++;
        if (oERR !== 1'b0) begin
            n_err++;
            $display("FAIL core_no_err got oERR=%b want 0", oERR);
        end
    endtask

    task automatic test_full_rate();
        int bo, bs, u, s, r, cnt;
        drive_load(100, 1'b0, 1'b0);
        drive_core(5, s, r);
        bo = o_data.size(); bs = stall_viol;
        drive_unload(100);
        check_outputs("full", bo, bs);
        u = src_rise[src_rise.size()-1];
        cnt = o_cyc.size() - bo;
        for (int k = 0; k < N && k < cnt; k++) begin
            n_cmp++;
            if (o_cyc[bo+k] != u + 2 + k) begin
                n_err++;
                $display("FAIL full_timing[%0d] got cycle %0d want %0d", k, o_cyc[bo+k], u + 2 + k);
            end
        end
        n_cmp++;
        if (cnt < 1 || rdy_rise[rdy_rise.size()-1] != o_cyc[o_cyc.size()-1] + 1) begin
            n_err++;
            $display("FAIL full_ready_after got %0d want %0d",
                     rdy_rise[rdy_rise.size()-1], o_cyc[o_cyc.size()-1] + 1);
        end
    endtask

    task automatic test_backpressure();
        int bo, bs, s, r;
        drive_load(80, 1'b0, 1'b0);
        drive_core(8, s, r);
        bo = o_data.size(); bs = stall_viol;
        drive_unload(30);
        check_outputs("bp", bo, bs);
    endtask

    task automatic test_timeout();
        int s, bo, bs;
        drive_load(100, 1'b0, 1'b0);
        wait_start(s);
        for (int i = 1; i <= 5; i++) begin
            @(posedge iCLK); #1;
            n_cmp++;
            if (oERR !== (i == 5) || oSOURCE_CONT !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_cycle%0d got err=%b src=%b want err=%b src=0",
                         i, oERR, oSOURCE_CONT, i == 5);
            end
        end
        @(posedge iCLK); #1;
        n_cmp++;
        if (oSOURCE_CONT !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_unload_entry got src=%b want 1", oSOURCE_CONT);
        end
        bo = o_data.size(); bs = stall_viol;
        drive_unload(70);
        check_outputs("timeout", bo, bs);
        n_cmp++;
        if (oERR !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky got oERR=%b want 1", oERR);
        end
    endtask

    task automatic test_reset_mid_unload();
        int s, r, bo, bs;
        drive_load(100, 1'b0, 1'b0);
        drive_core(5, s, r);
        iOUT_READY = 1'b1;
        repeat (10) begin
            @(posedge iCLK); #1;
        end
        n_cmp++;
        if (oOUT_VALID !== 1'b1 || oERR !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_pre got valid=%b err=%b want 1 1", oOUT_VALID, oERR);
        end
        #2 iRESET = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        iRESET = 1'b1;
        @(posedge iCLK); #1;
        drive_load(70, 1'b0, 1'b0);
        drive_core(6, s, r);
        bo = o_data.size(); bs = stall_viol;
        drive_unload(50);
        check_outputs("after_reset", bo, bs);
    endtask

    initial begin
        test_reset();
        test_load_mapping();
        test_gapped_input();
        test_core_handshake();
        test_full_rate();
        test_backpressure();
        test_timeout();
        test_reset_mid_unload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
